// File: rtl/quad_step_decoder_pkg.sv
// Shared types for the quadrature step decoder: FSM states, phase
// encodings and the transition classifier used by the top level.
package quad_pkg;

    typedef enum logic {
        INIT,
        TRACK
    } fsm_state_t;

    // Phase state is the filtered {A,B} pair.
    typedef logic [1:0] phase_t;

    localparam phase_t S00 = 2'b00;
    localparam phase_t S10 = 2'b10;
    localparam phase_t S11 = 2'b11;
    localparam phase_t S01 = 2'b01;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_ERR
    } step_t;

    // Successor of a phase in the up (A leads) direction.
    function automatic phase_t up_next(input phase_t p);
        case (p)
            S00:     return S10;
            S10:     return S11;
            S11:     return S01;
            default: return S00;
        endcase
    endfunction

    // Classify a move between two phase states.
    function automatic step_t next_dir(input phase_t prev, input phase_t cur);
        if (prev == cur)
            return STEP_NONE;
        else if ((prev ^ cur) == 2'b11)
            return STEP_ERR;
        else if (cur == up_next(prev))
            return STEP_UP;
        else
            return STEP_DN;
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-side and counter-side signals of the quadrature step decoder.
// The master drives the encoder phases and clears; the slave (decoder)
// drives the step, direction, position and status outputs.
interface quad_step_decoder_if #(
    parameter int WIDTH = 4
);
    logic             A;
    logic             B;
    logic             Clear;
    logic             Err_clr;
    logic             Step_en;
    logic             Up;
    logic [WIDTH-1:0] Position;
    logic             Err;
    logic             Ready;

    modport master (
        output A, B, Clear, Err_clr,
        input  Step_en, Up, Position, Err, Ready
    );

    modport slave (
        input  A, B, Clear, Err_clr,
        output Step_en, Up, Position, Err, Ready
    );
endinterface

// File: rtl/quad_step_decoder_input_sync_filter.sv
// Synchronizer chain plus stability filter for one asynchronous input.
// A new level is accepted only after it has been seen for FILTER_CYCLES
// consecutive cycles; valid rises after the first stable run after reset.
module input_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic Reset,
    input  logic din,
    output logic level,
    output logic valid
);
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   valid_q;
    logic                   sync_lvl;
    logic                   primed;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    // The chain holds reset values until SYNC_STAGES edges have passed.
    assign primed   = fill_q[SYNC_STAGES-1];

    // Synchronizer chain and fill tracker.
    // NOTE: the synchronizer flops are reset too, so a filter never sees a
    // stale pre-reset level and the restart after reset is deterministic.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Stability counter: initial run qualifies valid, later runs accept changes.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (primed) begin
            if (!valid_q) begin
                // Initial adoption: track the input until it sits still.
                if (sync_lvl != level_q) begin
                    level_q <= sync_lvl;
                    cnt_q   <= '0;
                end else if (cnt_q == CNT_MAX) begin
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (sync_lvl != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= sync_lvl;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                // Any return to the accepted level restarts the run.
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;
    assign valid = valid_q;
endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: turns filtered A/B phases into one-cycle step
// pulses with a direction flag, keeps a wrapping position count and a
// sticky error flag for transitions where both phases moved together.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic               clk,
    input  logic               Reset,
    quad_step_decoder_if.slave bus
);
    logic             lvl_a, lvl_b, valid_a, valid_b;
    phase_t           cur_phase;
    phase_t           phase_q;
    fsm_state_t       state_q;
    step_t            dir;
    logic             step_en_q, up_q, err_q, ready_q;
    logic [WIDTH-1:0] position_q;

    input_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_a (
        .clk  (clk),
        .Reset(Reset),
        .din  (bus.A),
        .level(lvl_a),
        .valid(valid_a)
    );

    input_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt_b (
        .clk  (clk),
        .Reset(Reset),
        .din  (bus.B),
        .level(lvl_b),
        .valid(valid_b)
    );

    assign cur_phase = {lvl_a, lvl_b};

    // Classify the move from the held phase state to the filtered inputs.
    // NOTE: dir is assigned on every path, so no latch is inferred.
    always_comb begin
        dir = STEP_NONE;
        if (state_q == TRACK)
            dir = next_dir(phase_q, cur_phase);
    end

    // INIT/TRACK FSM with registered step, direction, error and ready.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= INIT;
            phase_q   <= S00;
            step_en_q <= 1'b0;
            up_q      <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            step_en_q <= 1'b0;
            case (state_q)
                INIT: begin
                    if (valid_a && valid_b) begin
                        phase_q <= cur_phase;
                        ready_q <= 1'b1;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    case (dir)
                        STEP_UP: begin
                            step_en_q <= 1'b1;
                            up_q      <= 1'b1;
                            phase_q   <= cur_phase;
                        end
                        STEP_DN: begin
                            step_en_q <= 1'b1;
                            up_q      <= 1'b0;
                            phase_q   <= cur_phase;
                        end
                        STEP_ERR: phase_q <= cur_phase;
                        default:  ;
                    endcase
                end
                default: state_q <= INIT;
            endcase
            // A same-cycle illegal transition beats the error clear.
            if (dir == STEP_ERR)
                err_q <= 1'b1;
            else if (bus.Err_clr)
                err_q <= 1'b0;
        end
    end

    // Position follows the registered step outputs; Clear has priority.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            position_q <= '0;
        else if (bus.Clear)
            position_q <= '0;
        else if (step_en_q && up_q)
            position_q <= position_q + WIDTH'(1);
        else if (step_en_q)
            position_q <= position_q - WIDTH'(1);
    end

    assign bus.Step_en  = step_en_q;
    assign bus.Up       = up_q;
    assign bus.Position = position_q;
    assign bus.Err      = err_q;
    assign bus.Ready    = ready_q;
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed A/B vectors, each expected step
// pushed into a queue and popped by a monitor whenever Step_en is seen.
module tb_quad_step_decoder;
    localparam int WIDTH   = 4;
    localparam int LATENCY = 6;

    typedef struct {
        logic up;
        int   due;
    } exp_t;

    logic clk;
    logic Reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    quad_step_decoder_if #(.WIDTH(WIDTH)) bus ();

    quad_step_decoder #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(3)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change phases; a legal edge also queues the step it must cause.
    task automatic set_ab(input logic a, input logic b, input bit expect_step, input logic up);
        exp_t e;
        bus.A = a;
        bus.B = b;
        if (expect_step) begin
            e.up  = up;
            e.due = cyc + LATENCY;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every Step_en pulse must match the head of the queue.
    always @(negedge clk) begin
        if (!Reset && bus.Step_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("step_up", bus.Up, e.up);
                check("step_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        cyc      = 0;
        checks   = 0;
        failures = 0;
        Reset       = 1'b1;
        bus.A       = 1'b0;
        bus.B       = 1'b0;
        bus.Clear   = 1'b0;
        bus.Err_clr = 1'b0;

        // 1. reset state and ready timing with A=B=0
        tick(3);
        check("rst_ready", bus.Ready, 0);
        check("rst_step", bus.Step_en, 0);
        check("rst_pos", bus.Position, 0);
        check("rst_err", bus.Err, 0);
        Reset = 1'b0;
        tick(5);
        check("ready_edge5", bus.Ready, 0);
        tick(1);
        check("ready_edge6", bus.Ready, 1);
        tick(4);
        check("idle_pos", bus.Position, 0);
        check("idle_err", bus.Err, 0);

        // 2. five up edges
        set_ab(1, 0, 1, 1); tick(10);
        set_ab(1, 1, 1, 1); tick(10);
        set_ab(0, 1, 1, 1); tick(10);
        set_ab(0, 0, 1, 1); tick(10);
        set_ab(1, 0, 1, 1); tick(10);
        check("up5_pos", bus.Position, 5);
        check("up5_queue", exp_q.size(), 0);

        // 3. clear, one down edge wraps to 15, then clear on the step cycle
        bus.Clear = 1'b1; tick(1); bus.Clear = 1'b0; tick(1);
        check("clear_pos", bus.Position, 0);
        set_ab(0, 0, 1, 0); tick(10);
        check("down_wrap_pos", bus.Position, 15);
        set_ab(1, 0, 1, 1); tick(LATENCY);
        check("clr_step_visible", bus.Step_en, 1);
        bus.Clear = 1'b1; tick(1); bus.Clear = 1'b0;
        tick(3);
        check("clr_wins_pos", bus.Position, 0);

        // 4. two-cycle glitch on A is rejected
        set_ab(0, 0, 0, 0); tick(2);
        set_ab(1, 0, 0, 0); tick(10);
        check("glitch_pos", bus.Position, 0);
        check("glitch_err", bus.Err, 0);

        // 5. illegal double change, error clear, recovery
        set_ab(0, 0, 1, 0); tick(10);
        check("pre_err_pos", bus.Position, 15);
        set_ab(1, 1, 0, 0); tick(10);
        check("err_set", bus.Err, 1);
        check("err_pos", bus.Position, 15);
        bus.Err_clr = 1'b1; tick(1); bus.Err_clr = 1'b0; tick(1);
        check("err_cleared", bus.Err, 0);
        set_ab(0, 1, 1, 1); tick(10);
        check("recover_pos", bus.Position, 0);
        // illegal 01->10 with Err_clr on the same edge: the error wins
        set_ab(1, 0, 0, 0); tick(LATENCY - 1);
        bus.Err_clr = 1'b1; tick(1); bus.Err_clr = 1'b0;
        check("err_beats_clr", bus.Err, 1);
        tick(4);
        bus.Err_clr = 1'b1; tick(1); bus.Err_clr = 1'b0; tick(1);
        check("err_cleared2", bus.Err, 0);
        check("err2_pos", bus.Position, 0);

        // 6. asynchronous reset mid-sequence, restart at A=B=1
        set_ab(1, 1, 1, 1); tick(10);
        check("pre_rst_pos", bus.Position, 1);
        set_ab(0, 1, 0, 0); tick(3);
        #2 Reset = 1'b1;
        #1;
        check("midrst_ready", bus.Ready, 0);
        check("midrst_pos", bus.Position, 0);
        check("midrst_step", bus.Step_en, 0);
        check("midrst_up", bus.Up, 0);
        bus.A = 1'b1;
        bus.B = 1'b1;
        tick(3);
        Reset = 1'b0;
        for (int i = 0; i < 20 && bus.Ready !== 1'b1; i++) tick(1);
        check("ready_after_rst", bus.Ready, 1);
        tick(10);
        check("post_rst_err", bus.Err, 0);
        check("post_rst_pos", bus.Position, 0);
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound in case stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
